// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: state encoding and line levels shared by the serial transmitter.
// SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: parallel load side and serial line outputs of the transmitter.
interface serial_tx_if #(parameter int WIDTH = 8) ();

    logic [WIDTH-1:0] data;
    logic             load;
    logic             q;
    logic             busy;
    logic             done;

    modport master (output data, load, input q, busy, done);
    modport slave  (input data, load, output q, busy, done);

endinterface

// File: rtl/serial_tx_shift_reg.sv
// tx_shift_reg: loadable right-shift register with zero fill; ld wins over sh.
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             r,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic             lsb
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = ld ? d : sh ? {1'b0, sr_q[WIDTH-1:1]} : sr_q;
    end

    always_ff @(posedge c) begin
        sr_q <= r ? '0 : sr_d;
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/serial_tx.sv
// serial_tx: start bit, WIDTH data bits LSB first, stop bit; back-to-back loads accepted in STOP.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       c,
    input  logic       r,
    serial_tx_if.slave tx
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, last, lsb;

    assign accept = tx.load && (state_q == IDLE || state_q == STOP);
    assign last   = cnt_q == LAST;

    tx_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .c   (c),
        .r   (r),
        .ld  (accept),
        .sh  (state_q == DATA),
        .d   (tx.data),
        .lsb (lsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = accept ? START : IDLE;
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                cnt_d = last ? cnt_q : cnt_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                state_d = last ? PARITY : DATA;
`else
                state_d = last ? STOP : DATA;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            STOP:  state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        state_q <= r ? IDLE : state_d;
        cnt_q   <= r ? '0 : cnt_d;
    end

`ifdef SERIAL_TX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = state_q == START ? 1'b0 : state_q == DATA ? par_q ^ lsb : par_q;
    end

    always_ff @(posedge c) begin
        par_q <= r ? 1'b0 : par_d;
    end

    assign tx.q = state_q == START  ? START_BIT :
                  state_q == DATA   ? lsb :
                  state_q == PARITY ? par_q : LINE_IDLE;
`else
    assign tx.q = state_q == START ? START_BIT :
                  state_q == DATA  ? lsb : LINE_IDLE;
`endif

    assign tx.busy = state_q != IDLE;
    assign tx.done = state_q == STOP;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench; each accepted load queues the frame's per-cycle {q,busy,done}.
module tb_serial_tx;

    localparam int W = 8;

    logic c = 1'b0;
    logic r = 1'b1;

    serial_tx_if #(.WIDTH(W)) tx ();

    serial_tx #(.WIDTH(W)) dut (
        .c  (c),
        .r  (r),
        .tx (tx)
    );

    always #5 c = ~c;

    logic [2:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        exp_q.push_back(3'b010);
        for (int i = 0; i < W; i++) exp_q.push_back({d[i], 2'b10});
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back({^d, 2'b10});
`endif
        exp_q.push_back(3'b111);
    endtask

    // Queue empty at an edge means the line is idle or in its stop bit, so a load is taken.
    task automatic tick(input logic ld, input logic [W-1:0] d, input logic rs);
        logic [2:0] e;
        tx.load = ld;
        tx.data = d;
        r       = rs;
        @(posedge c);
        if (rs) exp_q.delete();
        else if (ld && exp_q.size() == 0) push_frame(d);
        @(negedge c);
        e = exp_q.size() != 0 ? exp_q.pop_front() : 3'b100;
        check("q", 32'(tx.q), 32'(e[2]));
        check("busy", 32'(tx.busy), 32'(e[1]));
        check("done", 32'(tx.done), 32'(e[0]));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1'b0, '0, 1'b0);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic frame(input logic [W-1:0] d);
        tick(1'b1, d, 1'b0);
        drain();
        tick(1'b0, '0, 1'b0);
    endtask

    initial begin
        tick(1'b1, '1, 1'b1);
        tick(1'b1, '1, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, 8'hA5, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0);
        drain();
        repeat (2) tick(1'b0, '0, 1'b0);
        tick(1'b1, 8'h01, 1'b0);
        drain();
        tick(1'b1, 8'h80, 1'b0);
        drain();
        repeat (2) tick(1'b0, '0, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        repeat (4) tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        repeat (3) tick(1'b0, '0, 1'b0);
        frame(8'h07);
        frame(8'h03);
        repeat (6) begin
            tick(1'b1, W'($urandom), 1'b0);
            drain();
            if ($urandom_range(1, 0) == 1) tick(1'b0, '0, 1'b0);
        end
        drain();
        repeat (2) tick(1'b0, '0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
